// File: rtl/rtlsta_arb.sv
// rtlsta_arb: engine-side scheduler in front of the CPU/engine RAM wrapper.
//   Shares the single engine read port and single engine write port among NREQ
//   requesters with independent round-robin arbitration, returns read data to the
//   issuing requester RDLAT cycles later, and forces an idle slot for the CPU path
//   after STARVE consecutive busy cycles while a CPU access is pending.
//
// Optional feature: define RTLSTA_ARB_INIT_EN to zero-fill the RAM after reset
//   (INIT state walks every address once before normal arbitration starts).
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_re/req_ra              per-requester read request (level) and packed address
//   req_we/req_wa/req_wrd      per-requester write request (level), packed address/data
//   gnt_rd/gnt_wr              one-hot single-cycle accepts (combinational)
//   rd_vld/rd_dat              one-hot read-return valid and shared read data
//   up_pend                    CPU access pending in the wrapper
//   eng_re/eng_ra              engine read port to the wrapper
//   eng_we/eng_wa/eng_wrd      engine write port to the wrapper
//   eng_rdd                    engine read data from the wrapper
//   active, init_done          engine enable to the wrapper, RAM ready
module rtlsta_arb #(
    parameter int unsigned ADDRBIT = 5,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned RDLAT   = 2,
    parameter int unsigned STARVE  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_re,
    input  logic [NREQ*ADDRBIT-1:0] req_ra,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*ADDRBIT-1:0] req_wa,
    input  logic [NREQ*WIDTH-1:0]   req_wrd,
    output logic [NREQ-1:0]         gnt_rd,
    output logic [NREQ-1:0]         gnt_wr,
    output logic [NREQ-1:0]         rd_vld,
    output logic [WIDTH-1:0]        rd_dat,
    input  logic                    up_pend,
    output logic                    eng_re,
    output logic [ADDRBIT-1:0]      eng_ra,
    output logic                    eng_we,
    output logic [ADDRBIT-1:0]      eng_wa,
    output logic [WIDTH-1:0]        eng_wrd,
    input  logic [WIDTH-1:0]        eng_rdd,
    output logic                    active,
    output logic                    init_done
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(STARVE + 1);

`ifdef RTLSTA_ARB_INIT_EN
    typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun} state_e;
`endif

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IW-1:0]    r_ptr_rd;
    logic [IW-1:0]    r_ptr_wr;
    logic [CW-1:0]    r_starve;
    logic [RDLAT-1:0] r_tag_vld;
    logic [IW-1:0]    r_tag_idx [RDLAT];
`ifdef RTLSTA_ARB_INIT_EN
    logic [ADDRBIT-1:0] r_init_addr;
`endif

    logic [IW:0]   w_rd_pick;
    logic [IW:0]   w_wr_pick;
    logic          w_rd_hit;
    logic          w_wr_hit;
    logic [IW-1:0] w_rd_idx;
    logic [IW-1:0] w_wr_idx;
    logic          w_force_idle;

    // Returns {hit, index}: first requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [IW:0] f_rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   ptr);
        logic [IW:0] pick;
        int          slot;
        pick = '0;
        // Scan from the farthest slot back so the slot nearest the pointer wins.
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            slot = int'(ptr) + k;
            if (slot >= int'(NREQ)) slot = slot - int'(NREQ);
            if (req[IW'(slot)]) pick = {1'b1, IW'(slot)};
        end
        return pick;
    endfunction

    assign w_rd_pick    = f_rr_pick(req_re, r_ptr_rd);
    assign w_wr_pick    = f_rr_pick(req_we, r_ptr_wr);
    assign w_rd_hit     = w_rd_pick[IW];
    assign w_wr_hit     = w_wr_pick[IW];
    assign w_rd_idx     = w_rd_pick[IW-1:0];
    assign w_wr_idx     = w_wr_pick[IW-1:0];
    // Counter reaching STARVE blanks both ports for one cycle to let the CPU in.
    assign w_force_idle = (r_starve == CW'(STARVE));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= StIdle;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
`ifdef RTLSTA_ARB_INIT_EN
                w_state_nxt = StInit;
`else
                w_state_nxt = StRun;
`endif
            end
`ifdef RTLSTA_ARB_INIT_EN
            StInit: begin
                if (!w_force_idle && (r_init_addr == '1)) w_state_nxt = StRun;
            end
`endif
            StRun:   w_state_nxt = StRun;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        gnt_rd    = '0;
        gnt_wr    = '0;
        eng_re    = 1'b0;
        eng_ra    = '0;
        eng_we    = 1'b0;
        eng_wa    = '0;
        eng_wrd   = '0;
        active    = 1'b0;
        init_done = 1'b0;
        case (r_state)
`ifdef RTLSTA_ARB_INIT_EN
            StInit: begin
                active = 1'b1;
                if (!w_force_idle) begin
                    eng_we = 1'b1;
                    eng_wa = r_init_addr;
                end
            end
`endif
            StRun: begin
                active    = 1'b1;
                init_done = 1'b1;
                if (!w_force_idle) begin
                    if (w_rd_hit) begin
                        gnt_rd[w_rd_idx] = 1'b1;
                        eng_re           = 1'b1;
                        eng_ra           = req_ra[int'(w_rd_idx) * ADDRBIT +: ADDRBIT];
                    end
                    if (w_wr_hit) begin
                        gnt_wr[w_wr_idx] = 1'b1;
                        eng_we           = 1'b1;
                        eng_wa           = req_wa[int'(w_wr_idx) * ADDRBIT +: ADDRBIT];
                        eng_wrd          = req_wrd[int'(w_wr_idx) * WIDTH +: WIDTH];
                    end
                end
            end
            default: ;
        endcase
    end

    // Round-robin pointers and starvation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr_rd <= '0;
            r_ptr_wr <= '0;
            r_starve <= '0;
        end else begin
            if (|gnt_rd) r_ptr_rd <= (w_rd_idx == IW'(NREQ - 1)) ? '0 : w_rd_idx + 1'b1;
            if (|gnt_wr) r_ptr_wr <= (w_wr_idx == IW'(NREQ - 1)) ? '0 : w_wr_idx + 1'b1;
            r_starve <= ((eng_re || eng_we) && up_pend) ? r_starve + 1'b1 : '0;
        end
    end

`ifdef RTLSTA_ARB_INIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              r_init_addr <= '0;
        else if ((r_state == StInit) && eng_we) r_init_addr <= r_init_addr + 1'b1;
    end
`endif

    // Read tag pipe: carries the granted requester index alongside the RAM latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            for (int s = 0; s < int'(RDLAT); s++) r_tag_idx[s] <= '0;
        end else begin
            r_tag_vld[0] <= eng_re;
            r_tag_idx[0] <= w_rd_idx;
            for (int s = 1; s < int'(RDLAT); s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    always_comb begin
        rd_vld = '0;
        rd_dat = '0;
        if (r_tag_vld[RDLAT-1]) begin
            rd_vld[r_tag_idx[RDLAT-1]] = 1'b1;
            rd_dat                     = eng_rdd;
        end
    end

endmodule

// File: tb/tb_rtlsta_arb.sv
// tb_rtlsta_arb: randomized and directed checks of rtlsta_arb against a behavioural
//   model; the bench also plays the RAM wrapper (memory array + read latency).
//   Honours RTLSTA_ARB_INIT_EN when the design is built with it.
module tb_rtlsta_arb;
    localparam int ADDRBIT = 5;
    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int RDLAT   = 2;
    localparam int STARVE  = 15;
    localparam int DEPTH   = 1 << ADDRBIT;
`ifdef RTLSTA_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_re;
    logic [NREQ*ADDRBIT-1:0] req_ra;
    logic [NREQ-1:0]         req_we;
    logic [NREQ*ADDRBIT-1:0] req_wa;
    logic [NREQ*WIDTH-1:0]   req_wrd;
    logic [NREQ-1:0]         gnt_rd;
    logic [NREQ-1:0]         gnt_wr;
    logic [NREQ-1:0]         rd_vld;
    logic [WIDTH-1:0]        rd_dat;
    logic                    up_pend;
    logic                    eng_re;
    logic [ADDRBIT-1:0]      eng_ra;
    logic                    eng_we;
    logic [ADDRBIT-1:0]      eng_wa;
    logic [WIDTH-1:0]        eng_wrd;
    logic [WIDTH-1:0]        eng_rdd;
    logic                    active;
    logic                    init_done;

    rtlsta_arb #(
        .ADDRBIT(ADDRBIT),
        .WIDTH  (WIDTH),
        .NREQ   (NREQ),
        .RDLAT  (RDLAT),
        .STARVE (STARVE)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_re   (req_re),
        .req_ra   (req_ra),
        .req_we   (req_we),
        .req_wa   (req_wa),
        .req_wrd  (req_wrd),
        .gnt_rd   (gnt_rd),
        .gnt_wr   (gnt_wr),
        .rd_vld   (rd_vld),
        .rd_dat   (rd_dat),
        .up_pend  (up_pend),
        .eng_re   (eng_re),
        .eng_ra   (eng_ra),
        .eng_we   (eng_we),
        .eng_wa   (eng_wa),
        .eng_wrd  (eng_wrd),
        .eng_rdd  (eng_rdd),
        .active   (active),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        int               idx;
        logic [WIDTH-1:0] data;
    } rd_t;

    // Requester-side stimulus state
    logic               rq_re  [NREQ];
    logic [ADDRBIT-1:0] rq_ra  [NREQ];
    logic               rq_we  [NREQ];
    logic [ADDRBIT-1:0] rq_wa  [NREQ];
    logic [WIDTH-1:0]   rq_wrd [NREQ];
    logic               up_v;
    bit                 auto_mode;

    // Behavioural model state
    int               m_ptr_rd, m_ptr_wr, m_busy, m_cyc, m_init_addr, m_t;
    logic [WIDTH-1:0] mem [DEPTH];
    rd_t              rdq [$];

    // Outputs captured at the last compare point
    logic [NREQ-1:0]    l_gnt_rd, l_gnt_wr, l_rd_vld;
    logic [WIDTH-1:0]   l_rd_dat, l_eng_wrd;
    logic [ADDRBIT-1:0] l_eng_wa;
    logic               l_eng_re, l_eng_we, l_active, l_init_done;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got 0x%0h, want 0x%0h", name, m_t, act, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr_rd    = 0;
        m_ptr_wr    = 0;
        m_busy      = 0;
        m_cyc       = 0;
        m_init_addr = 0;
        rdq.delete();
    endtask

    task automatic capture();
        l_gnt_rd = gnt_rd;   l_gnt_wr = gnt_wr;     l_rd_vld = rd_vld;  l_rd_dat = rd_dat;
        l_eng_re = eng_re;   l_eng_we = eng_we;     l_eng_wa = eng_wa;  l_eng_wrd = eng_wrd;
        l_active = active;   l_init_done = init_done;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, advance the model.
    task automatic step(input logic rst_v);
        logic [NREQ-1:0]    one, e_grd, e_gwr, e_vld;
        logic [WIDTH-1:0]   e_dat, e_wrd;
        logic [ADDRBIT-1:0] e_wa;
        logic               e_re, e_we;
        bit                 in_run, in_init, hold;
        int                 rd_w, wr_w;
        rd_t                ent;
        one = 1;
        @(negedge clk);
        rst = rst_v;
        for (int i = 0; i < NREQ; i++) begin
            req_re[i]                      = rq_re[i];
            req_ra[i*ADDRBIT +: ADDRBIT]   = rq_ra[i];
            req_we[i]                      = rq_we[i];
            req_wa[i*ADDRBIT +: ADDRBIT]   = rq_wa[i];
            req_wrd[i*WIDTH +: WIDTH]      = rq_wrd[i];
        end
        up_pend = up_v;
        if (rdq.size() > 0 && rdq[0].due == m_t) eng_rdd = rdq[0].data;
        else                                     eng_rdd = WIDTH'($urandom);
        #1;
        capture();
        if (!rst_v) begin
            chk("rst_gnt_rd", gnt_rd, 0);    chk("rst_gnt_wr", gnt_wr, 0);
            chk("rst_rd_vld", rd_vld, 0);    chk("rst_rd_dat", rd_dat, 0);
            chk("rst_eng_re", eng_re, 0);    chk("rst_eng_ra", eng_ra, 0);
            chk("rst_eng_we", eng_we, 0);    chk("rst_eng_wa", eng_wa, 0);
            chk("rst_eng_wrd", eng_wrd, 0);  chk("rst_active", active, 0);
            chk("rst_init_done", init_done, 0);
            m_reset();
            m_t++;
            return;
        end

        in_run  = (m_cyc >= 1) && (!INIT_EN || m_init_addr >= DEPTH);
        in_init = INIT_EN && (m_cyc >= 1) && (m_init_addr < DEPTH);
        hold    = (m_busy == STARVE);
        rd_w = -1;
        wr_w = -1;
        if (in_run && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                int s;
                s = (m_ptr_rd + k) % NREQ;
                if (rd_w < 0 && rq_re[s]) rd_w = s;
                s = (m_ptr_wr + k) % NREQ;
                if (wr_w < 0 && rq_we[s]) wr_w = s;
            end
        end
        e_re  = (rd_w >= 0);
        e_grd = e_re ? (one << rd_w) : '0;
        e_gwr = (wr_w >= 0) ? (one << wr_w) : '0;
        e_we  = (wr_w >= 0) || (in_init && !hold);
        e_wa  = (wr_w >= 0) ? rq_wa[wr_w] : ADDRBIT'(m_init_addr);
        e_wrd = (wr_w >= 0) ? rq_wrd[wr_w] : '0;
        e_vld = '0;
        e_dat = '0;
        if (rdq.size() > 0 && rdq[0].due == m_t) begin
            e_vld = one << rdq[0].idx;
            e_dat = rdq[0].data;
        end

        chk("gnt_rd", gnt_rd, e_grd);
        chk("gnt_wr", gnt_wr, e_gwr);
        chk("eng_re", eng_re, e_re);
        chk("eng_we", eng_we, e_we);
        if (e_re) chk("eng_ra", eng_ra, rq_ra[rd_w]);
        if (e_we) begin
            chk("eng_wa", eng_wa, e_wa);
            chk("eng_wrd", eng_wrd, e_wrd);
        end
        chk("rd_vld", rd_vld, e_vld);
        chk("rd_dat", rd_dat, e_dat);
        chk("active", active, in_run || in_init);
        chk("init_done", init_done, in_run);

        // Advance model: wrapper memory, return queue, pointers, starvation run length.
        if (e_vld != 0) void'(rdq.pop_front());
        if (e_re) begin
            ent.due  = m_t + RDLAT;
            ent.idx  = rd_w;
            ent.data = mem[rq_ra[rd_w]];
            rdq.push_back(ent);
        end
        if (e_we) mem[e_wa] = e_wrd;
        if (rd_w >= 0) m_ptr_rd = (rd_w + 1) % NREQ;
        if (wr_w >= 0) m_ptr_wr = (wr_w + 1) % NREQ;
        m_busy = ((e_re || e_we) && up_v) ? m_busy + 1 : 0;
        if (in_init && e_we) m_init_addr++;
        m_cyc++;
        if (auto_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rd_w == i) begin
                    if ($urandom_range(0, 9) < 6) rq_ra[i] = ADDRBIT'($urandom);
                    else                          rq_re[i] = 1'b0;
                end else if (!rq_re[i] && $urandom_range(0, 3) == 0) begin
                    rq_re[i] = 1'b1;
                    rq_ra[i] = ADDRBIT'($urandom);
                end
                if (wr_w == i) begin
                    if ($urandom_range(0, 9) < 6) begin
                        rq_wa[i]  = ADDRBIT'($urandom);
                        rq_wrd[i] = WIDTH'($urandom);
                    end else rq_we[i] = 1'b0;
                end else if (!rq_we[i] && $urandom_range(0, 3) == 0) begin
                    rq_we[i]  = 1'b1;
                    rq_wa[i]  = ADDRBIT'($urandom);
                    rq_wrd[i] = WIDTH'($urandom);
                end
            end
        end
        m_t++;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            rq_re[i] = 1'b0;
            rq_we[i] = 1'b0;
        end
    endtask

    // Release reset, then walk through the idle cycle (and the init fill when built in).
    task automatic post_release();
        step(1'b1);
        chk("idle_active", l_active, 0);
        chk("idle_rd_vld", l_rd_vld, 0);
`ifdef RTLSTA_ARB_INIT_EN
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1);
            chk("init_we", l_eng_we, 1);
            chk("init_wa", l_eng_wa, k);
            chk("init_gnt", {l_gnt_rd, l_gnt_wr}, 0);
        end
        step(1'b1);
        chk("init_done_rise", l_init_done, 1);
`endif
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq_re[i] = 1'b0; rq_ra[i] = '0; rq_we[i] = 1'b0; rq_wa[i] = '0; rq_wrd[i] = '0;
        end
        rst       = 1'b0;
        req_re    = '0; req_ra = '0; req_we = '0; req_wa = '0; req_wrd = '0;
        up_pend   = 1'b0;
        eng_rdd   = '0;
        up_v      = 1'b0;
        auto_mode = 1'b0;
        m_t       = 0;
        m_reset();

        step(1'b0);
        step(1'b0);
        post_release();

        // All four readers held: grants rotate 0,1,2,3 and data returns RDLAT later.
        for (int i = 0; i < NREQ; i++) rq_ra[i] = ADDRBIT'(i + 4);
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NREQ; i++) rq_re[i] = (k < 8);
            step(1'b1);
            if (k < 8)  chk("rr_gnt_rd", l_gnt_rd, 4'b0001 << (k % 4));
            if (k >= 2) chk("rr_rd_vld", l_rd_vld, 4'b0001 << ((k - 2) % 4));
        end

        // Requester 1 writes 0xA5A5A5A5 to address 3; write pointer moves to 2.
        rq_we[1] = 1'b1; rq_wa[1] = 5'd3; rq_wrd[1] = 32'hA5A5_A5A5;
        step(1'b1);
        chk("w1_gnt_wr", l_gnt_wr, 4'b0010);
        chk("w1_eng_wa", l_eng_wa, 3);
        rq_we[0] = 1'b1; rq_wa[0] = 5'd7; rq_wrd[0] = 32'h1234_5678;
        rq_wa[1] = 5'd9; rq_wrd[1] = 32'hCAFE_F00D;
        step(1'b1);
        chk("wrap_gnt_wr0", l_gnt_wr, 4'b0001);
        chk("wrap_wa0", l_eng_wa, 7);
        chk("wrap_wrd0", l_eng_wrd, 32'h1234_5678);
        rq_we[0] = 1'b0;
        step(1'b1);
        chk("wrap_gnt_wr1", l_gnt_wr, 4'b0010);
        chk("wrap_wa1", l_eng_wa, 9);
        chk("wrap_wrd1", l_eng_wrd, 32'hCAFE_F00D);
        rq_we[1] = 1'b0;

        // Requester 2 reads address 3 back.
        rq_re[2] = 1'b1; rq_ra[2] = 5'd3;
        step(1'b1);
        chk("rb_gnt_rd", l_gnt_rd, 4'b0100);
        rq_re[2] = 1'b0;
        step(1'b1);
        step(1'b1);
        chk("rb_rd_vld", l_rd_vld, 4'b0100);
        chk("rb_rd_dat", l_rd_dat, 32'hA5A5_A5A5);

        // Saturated ports with CPU pending: one blank cycle in every 16.
        step(1'b1);
        for (int i = 0; i < NREQ; i++) begin
            rq_re[i] = 1'b1; rq_ra[i] = ADDRBIT'($urandom);
            rq_we[i] = 1'b1; rq_wa[i] = ADDRBIT'($urandom); rq_wrd[i] = WIDTH'($urandom);
        end
        up_v = 1'b1;
        for (int k = 0; k < 48; k++) begin
            step(1'b1);
            chk("starve_idle", !(l_eng_re || l_eng_we), (k % 16) == 15);
        end
        clear_reqs();
        up_v = 1'b0;
        step(1'b1);
        step(1'b1);
        step(1'b1);

        // Reset one cycle after a read grant: the pending return must vanish.
        rq_re[0] = 1'b1; rq_ra[0] = 5'd3;
        step(1'b1);
        chk("rst_rd_gnt", l_gnt_rd, 4'b0001);
        rq_re[0] = 1'b0;
        step(1'b0);
        post_release();
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            chk("post_rst_rd_vld", l_rd_vld, 0);
        end

        // Randomized traffic with bursts of CPU pressure and one mid-run reset.
        auto_mode = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            up_v = ((c / 64) % 2 == 1) ? 1'b1 : ($urandom_range(0, 9) < 5);
            if (c == 700 || c == 701) step(1'b0);
            else                      step(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
